// File: rtl/player_missile.sv
// Player missile: launches on a fire edge, climbs SPEED px per frame, hit-tests the enemy grid.
// Latency: launch and every move or hit appear one vsync after the triggering frame; kill is a one-frame strobe.
// No flow control: runs once per vsync; fire is ignored while in flight, in HIT or during cooldown.
module player_missile #(
  parameter int SPEED    = 6,
  parameter int SPAWN_Y  = 440,
  parameter int COOLDOWN = 15
) (
  input  logic            vsync,
  input  logic            reset,
  input  logic            fire,
  input  logic [3:0]      state,
  input  logic [9:0]      playerX,
  input  logic [9:0]      enemy_offset,
  input  logic [9:0][5:0] enemy_status,
  output logic            exists,
  output logic [9:0]      missileX,
  output logic [9:0]      missileY,
  output logic            kill,
  output logic [3:0]      kill_col,
  output logic [2:0]      kill_row
);

  localparam logic [9:0] SPD     = 10'(SPEED);
  localparam logic [9:0] SPAWN   = 10'(SPAWN_Y);
  localparam logic [7:0] CD_INIT = 8'(COOLDOWN);

  typedef enum logic [1:0] {IDLE, FLYING, HIT} fsm_t;

  fsm_t       fsm;
  logic [7:0] cooldown;
  logic       fire_d;

  // Hit-test terms derived from the current missile position and the live grid
  logic [9:0] rel_x;
  logic [9:0] rel_y;
  logic [3:0] hit_col;
  logic [2:0] hit_row;
  logic       x_ok;
  logic       y_ok;
  logic       hit;

  // Map the missile position onto a grid cell; 64-px columns whose left 32 px hold the sprite, 32-px rows from Y=32
  always_comb begin
    rel_x   = missileX - enemy_offset;
    rel_y   = missileY - 10'd32;
    hit_col = 4'(rel_x >> 6);
    hit_row = 3'(rel_y >> 5);
    x_ok    = (missileX >= enemy_offset) && (hit_col <= 4'd9) && ((rel_x & 10'h03F) < 10'd32);
    y_ok    = (missileY >= 10'd32) && (missileY < 10'd224);
    hit     = 1'b0;
    if (x_ok && y_ok) begin
      hit = enemy_status[hit_col][hit_row];
    end
  end

  // Missile FSM with registered outputs; leaving game state 1 aborts everything except fire edge tracking
  always_ff @(posedge vsync or negedge reset) begin
    if (!reset) begin
      fsm      <= IDLE;
      cooldown <= 8'd0;
      fire_d   <= 1'b0;
      exists   <= 1'b0;
      missileX <= 10'd0;
      missileY <= 10'd0;
      kill     <= 1'b0;
      kill_col <= 4'd0;
      kill_row <= 3'd0;
    end else begin
      fire_d <= fire;
      if (state != 4'd1) begin
        fsm      <= IDLE;
        cooldown <= 8'd0;
        exists   <= 1'b0;
        missileX <= 10'd0;
        missileY <= 10'd0;
        kill     <= 1'b0;
        kill_col <= 4'd0;
        kill_row <= 3'd0;
      end else begin
        case (fsm)
          IDLE: begin
            if (cooldown != 8'd0) begin
              cooldown <= cooldown - 8'd1;
            end else if (fire && !fire_d) begin
              missileX <= playerX + 10'd16;
              missileY <= SPAWN;
              exists   <= 1'b1;
              fsm      <= FLYING;
            end
          end
          FLYING: begin
            // A hit takes priority over leaving the top of the screen
            if (hit) begin
              kill_col <= hit_col;
              kill_row <= hit_row;
              kill     <= 1'b1;
              exists   <= 1'b0;
              fsm      <= HIT;
            end else if (missileY <= SPD) begin
              exists   <= 1'b0;
              cooldown <= CD_INIT;
              fsm      <= IDLE;
            end else begin
              missileY <= missileY - SPD;
            end
          end
          HIT: begin
            kill     <= 1'b0;
            exists   <= 1'b0;
            cooldown <= CD_INIT;
            fsm      <= IDLE;
          end
          default: begin
            fsm <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_player_missile.sv
// Bench for player_missile: scripted scenarios with literal expectations, then randomized frames.
// Latency: outputs are compared one frame after the inputs that caused them.
// No flow control: inputs are driven 2 time units after each vsync rising edge.
module tb_player_missile;

  logic            vsync;
  logic            reset;
  logic            fire;
  logic [3:0]      state;
  logic [9:0]      playerX;
  logic [9:0]      enemy_offset;
  logic [9:0][5:0] enemy_status;
  logic            exists;
  logic [9:0]      missileX;
  logic [9:0]      missileY;
  logic            kill;
  logic [3:0]      kill_col;
  logic [2:0]      kill_row;

  int total = 0;
  int bad   = 0;
  int cycle = 0;

  player_missile dut (
    .vsync        (vsync),
    .reset        (reset),
    .fire         (fire),
    .state        (state),
    .playerX      (playerX),
    .enemy_offset (enemy_offset),
    .enemy_status (enemy_status),
    .exists       (exists),
    .missileX     (missileX),
    .missileY     (missileY),
    .kill         (kill),
    .kill_col     (kill_col),
    .kill_row     (kill_row)
  );

  initial begin
    vsync = 1'b0;
    forever #5 vsync = ~vsync;
  end

  // ---------------- behavioural model ----------------
  int m_exists = 0;
  int m_x      = 0;
  int m_y      = 0;
  int m_kill   = 0;
  int m_kcol   = 0;
  int m_krow   = 0;
  int m_cd     = 0;
  int m_fd     = 0;

  int h_col;
  int h_row;
  bit h_hit;

  function automatic bit model_hit(input int x, input int y, input int off,
                                   input logic [9:0][5:0] st,
                                   output int col, output int row);
    int rel;
    col = 0;
    row = 0;
    if (x < off) return 1'b0;
    rel = x - off;
    col = rel / 64;
    if (col > 9) return 1'b0;
    if ((rel % 64) >= 32) return 1'b0;
    if (y < 32 || y >= 224) return 1'b0;
    row = (y - 32) / 32;
    return st[col][row];
  endfunction

  always_comb begin
    h_col = 0;
    h_row = 0;
    h_hit = model_hit(m_x, m_y, int'(enemy_offset), enemy_status, h_col, h_row);
  end

  always @(posedge vsync or negedge reset) begin
    if (!reset) begin
      m_exists <= 0; m_x <= 0; m_y <= 0; m_kill <= 0;
      m_kcol <= 0; m_krow <= 0; m_cd <= 0; m_fd <= 0;
    end else begin
      m_fd <= int'(fire);
      if (state != 4'd1) begin
        m_exists <= 0; m_x <= 0; m_y <= 0; m_kill <= 0;
        m_kcol <= 0; m_krow <= 0; m_cd <= 0;
      end else if (m_kill != 0) begin
        m_kill <= 0;
        m_cd   <= 15;
      end else if (m_exists != 0) begin
        if (h_hit) begin
          m_exists <= 0;
          m_kill   <= 1;
          m_kcol   <= h_col;
          m_krow   <= h_row;
        end else if (m_y <= 6) begin
          m_exists <= 0;
          m_cd     <= 15;
        end else begin
          m_y <= m_y - 6;
        end
      end else if (m_cd > 0) begin
        m_cd <= m_cd - 1;
      end else if (fire && m_fd == 0) begin
        m_exists <= 1;
        m_x      <= (int'(playerX) + 16) % 1024;
        m_y      <= 440;
      end
    end
  end

  // Compare every output against the model mid-frame
  always @(negedge vsync) begin
    cycle++;
    total++;
    if (int'(exists) != m_exists || int'(missileX) != m_x || int'(missileY) != m_y ||
        int'(kill) != m_kill || int'(kill_col) != m_kcol || int'(kill_row) != m_krow) begin
      bad++;
      $display("FAIL model cycle %0d: dut ex=%0d x=%0d y=%0d kill=%0d col=%0d row=%0d expected ex=%0d x=%0d y=%0d kill=%0d col=%0d row=%0d",
               cycle, exists, missileX, missileY, kill, kill_col, kill_row,
               m_exists, m_x, m_y, m_kill, m_kcol, m_krow);
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge vsync);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int  launches;
    bit  prev_ex;
    bit  found;
    logic [63:0] rnd;

    reset        = 1'b1;
    fire         = 1'b0;
    state        = 4'd1;
    playerX      = 10'd64;
    enemy_offset = 10'd0;
    enemy_status = '0;
    #1 reset = 1'b0;
    ticks(2);
    chk("reset exists", int'(exists), 0);
    chk("reset missileY", int'(missileY), 0);
    chk("reset kill", int'(kill), 0);
    reset = 1'b1;

    // Launch from playerX = 64
    tick();
    fire = 1'b1;
    tick();
    chk("launch exists", int'(exists), 1);
    chk("launch missileX", int'(missileX), 80);
    chk("launch missileY", int'(missileY), 440);
    fire = 1'b0;
    tick();
    chk("frame2 missileY", int'(missileY), 434);

    // Full grid alive: hit at column 1, row 5 when Y = 218
    enemy_status = '1;
    ticks(36);
    chk("frame38 missileY", int'(missileY), 218);
    chk("frame38 kill", int'(kill), 0);
    tick();
    chk("frame39 kill", int'(kill), 1);
    chk("frame39 kill_col", int'(kill_col), 1);
    chk("frame39 kill_row", int'(kill_row), 5);
    chk("frame39 exists", int'(exists), 0);
    tick();
    chk("frame40 kill", int'(kill), 0);

    // Gap between sprites: no kill, exits top, then cooldown
    ticks(15);
    playerX = 10'd96;
    fire = 1'b1;
    tick();
    fire = 1'b0;
    chk("gap launch missileX", int'(missileX), 112);
    ticks(72);
    chk("gap Y=8", int'(missileY), 8);
    tick();
    chk("gap Y=2", int'(missileY), 2);
    chk("gap still exists", int'(exists), 1);
    tick();
    chk("gap despawn exists", int'(exists), 0);
    for (int k = 1; k <= 16; k++) begin
      fire = (k % 2 == 0);
      tick();
      chk($sformatf("cooldown frame %0d exists", k), int'(exists), (k == 16) ? 1 : 0);
    end
    fire = 1'b0;
    ticks(3);

    // Abort by leaving game state
    state = 4'd2;
    tick();
    chk("abort exists", int'(exists), 0);
    chk("abort kill", int'(kill), 0);
    state = 4'd1;
    tick();

    // Dead enemy at [1][5]: passes row 5, kills row 4 at Y = 188
    enemy_status = '1;
    enemy_status[1][5] = 1'b0;
    playerX = 10'd64;
    fire = 1'b1;
    tick();
    fire = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (kill) found = 1'b1;
    end
    chk("dead enemy kill seen", int'(found), 1);
    chk("dead enemy kill_col", int'(kill_col), 1);
    chk("dead enemy kill_row", int'(kill_row), 4);
    chk("dead enemy missileY", int'(missileY), 188);

    // Held fire: one launch only
    enemy_status = '0;
    ticks(20);
    launches = 0;
    prev_ex  = 1'b0;
    fire = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (exists && !prev_ex) launches++;
      prev_ex = exists;
    end
    chk("held fire launches", launches, 1);
    fire = 1'b0;
    tick();
    fire = 1'b1;
    tick();
    chk("refire exists", int'(exists), 1);
    fire = 1'b0;
    ticks(5);

    // Asynchronous reset mid-flight
    chk("preflight exists", int'(exists), 1);
    reset = 1'b0;
    #1;
    chk("async reset exists", int'(exists), 0);
    chk("async reset missileX", int'(missileX), 0);
    chk("async reset missileY", int'(missileY), 0);
    chk("async reset kill", int'(kill), 0);
    chk("async reset kill_col", int'(kill_col), 0);
    chk("async reset kill_row", int'(kill_row), 0);
    tick();
    reset = 1'b1;

    // Randomized frames against the model
    enemy_status = '1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      reset = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      state = ($urandom_range(0, 149) == 0) ? 4'(1 + $urandom_range(1, 14)) : 4'd1;
      fire  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0) playerX = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 39) == 0) enemy_offset = 10'($urandom_range(0, 400));
      if ($urandom_range(0, 29) == 0) begin
        rnd = {$urandom(), $urandom()};
        enemy_status = rnd[59:0] | {rnd[63:60], rnd[55:0]};
      end
    end
    reset = 1'b1;
    state = 4'd1;
    ticks(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
